// File: rtl/cmac_axis_pkt_gen.sv
// Deterministic-pattern frame generator for the 512-bit CMAC AXI4-Stream TX port.
// Frame byte n carries (seq + n) mod 256; frames start only while RX is aligned.
module cmac_axis_pkt_gen #(
  parameter int GAP_CYCLES = 2,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 9600
) (
  input  logic         clk,
  input  logic         sys_reset_n,
  input  logic         start,
  input  logic         send_continuous,
  input  logic         stat_rx_aligned,
  input  logic [15:0]  num_pkts,
  input  logic [13:0]  pkt_len,
  input  logic         tx_axis_tready,
  output logic         tx_axis_tvalid,
  output logic [511:0] tx_axis_tdata,
  output logic [63:0]  tx_axis_tkeep,
  output logic         tx_axis_tlast,
  output logic         tx_busy,
  output logic         tx_done,
  output logic [31:0]  pkts_sent
);
  typedef enum logic [2:0] {IDLE, WAIT_ALIGN, SEND, GAP, DONE} state_t;
  state_t state_reg, state_next;

  logic [1:0]   rst_sync_reg;
  logic [15:0]  num_pkts_reg;
  logic         cont_reg;
  logic [7:0]   num_beats_reg;
  logic [5:0]   len_rem_reg;
  logic [7:0]   seq_reg;
  logic [7:0]   beat_idx_reg;
  logic [15:0]  gap_cnt_reg;

  logic [13:0]  len_clamped;
  logic         xfer, last_xfer, do_start, load_beat, frame_more;
  logic [31:0]  pkts_inc, pkts_chk;
  logic [7:0]   next_idx, next_base;
  logic         next_last;
  logic [63:0]  next_keep;
  logic [511:0] next_data;

  always_comb begin
    len_clamped = pkt_len;
    if (pkt_len < 14'(MIN_LEN))
      len_clamped = 14'(MIN_LEN);
    else if (pkt_len > 14'(MAX_LEN))
      len_clamped = 14'(MAX_LEN);
  end

  // start is honoured only once reset release has crossed both sync stages
  assign do_start  = start && rst_sync_reg[1] && (state_reg == IDLE || state_reg == DONE);
  assign xfer      = tx_axis_tvalid && tx_axis_tready;
  assign last_xfer = xfer && tx_axis_tlast;
  assign pkts_inc  = (pkts_sent == 32'hFFFF_FFFF) ? pkts_sent : pkts_sent + 32'd1;

  always_comb begin
    state_next = state_reg;
    load_beat  = 1'b0;
    // leaving SEND directly must see the count including the frame just finished
    pkts_chk   = (state_reg == SEND) ? pkts_inc : pkts_sent;
    frame_more = cont_reg ? send_continuous : (pkts_chk != {16'd0, num_pkts_reg});
    case (state_reg)
      IDLE, DONE: if (do_start) state_next = WAIT_ALIGN;
      WAIT_ALIGN: begin
        if (!cont_reg && num_pkts_reg == 16'd0) begin
          state_next = DONE;
        end else if (stat_rx_aligned) begin
          state_next = SEND;
          load_beat  = 1'b1;
        end
      end
      SEND: begin
        if (last_xfer) begin
          if (GAP_CYCLES == 0) state_next = frame_more ? WAIT_ALIGN : DONE;
          else                 state_next = GAP;
        end else if (xfer) begin
          load_beat = 1'b1;
        end
      end
      GAP: if (gap_cnt_reg == 16'(GAP_CYCLES - 1)) state_next = frame_more ? WAIT_ALIGN : DONE;
      default: state_next = IDLE;
    endcase
  end

  // Beat about to be presented: first beat from WAIT_ALIGN, successor while in SEND
  assign next_idx  = (state_reg == SEND) ? beat_idx_reg + 8'd1 : 8'd0;
  assign next_last = (next_idx == num_beats_reg - 8'd1);
  assign next_keep = !next_last ? '1 :
                     (len_rem_reg == 6'd0) ? '1 : (64'd1 << len_rem_reg) - 64'd1;
  assign next_base = seq_reg + {next_idx[1:0], 6'd0};

  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_byte
      assign next_data[8*gi +: 8] = next_keep[gi] ? next_base + 8'(gi) : 8'd0;
    end
  endgenerate

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) rst_sync_reg <= 2'b00;
    else              rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) state_reg <= IDLE;
    else              state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      num_pkts_reg   <= '0;
      cont_reg       <= 1'b0;
      num_beats_reg  <= '0;
      len_rem_reg    <= '0;
      seq_reg        <= '0;
      beat_idx_reg   <= '0;
      gap_cnt_reg    <= '0;
      pkts_sent      <= '0;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tdata  <= '0;
      tx_axis_tkeep  <= '0;
      tx_axis_tlast  <= 1'b0;
      tx_busy        <= 1'b0;
      tx_done        <= 1'b0;
    end else begin
      tx_busy     <= (state_next == WAIT_ALIGN) || (state_next == SEND) || (state_next == GAP);
      tx_done     <= (state_next == DONE);
      gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + 16'd1 : 16'd0;
      if (do_start) begin
        num_pkts_reg  <= num_pkts;
        cont_reg      <= send_continuous;
        num_beats_reg <= 8'((len_clamped + 14'd63) >> 6);
        len_rem_reg   <= len_clamped[5:0];
        seq_reg       <= '0;
        pkts_sent     <= '0;
      end
      if (load_beat) begin
        tx_axis_tvalid <= 1'b1;
        tx_axis_tdata  <= next_data;
        tx_axis_tkeep  <= next_keep;
        tx_axis_tlast  <= next_last;
        beat_idx_reg   <= next_idx;
      end else if (last_xfer) begin
        tx_axis_tvalid <= 1'b0;
        tx_axis_tdata  <= '0;
        tx_axis_tkeep  <= '0;
        tx_axis_tlast  <= 1'b0;
        pkts_sent      <= pkts_inc;
        seq_reg        <= seq_reg + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_cmac_axis_pkt_gen.sv
// Directed bench for cmac_axis_pkt_gen: table of frame runs plus hand sequences
// for reset, zero count, alignment gating, continuous mode and mid-frame reset.
module tb_cmac_axis_pkt_gen;
  logic         clk = 1'b0;
  logic         sys_reset_n = 1'b1;
  logic         start = 1'b0;
  logic         send_continuous = 1'b0;
  logic         stat_rx_aligned = 1'b1;
  logic [15:0]  num_pkts = 16'd0;
  logic [13:0]  pkt_len = 14'd64;
  logic         tx_axis_tready = 1'b1;
  logic         tx_axis_tvalid;
  logic [511:0] tx_axis_tdata;
  logic [63:0]  tx_axis_tkeep;
  logic         tx_axis_tlast;
  logic         tx_busy;
  logic         tx_done;
  logic [31:0]  pkts_sent;

  always #5 clk = ~clk;

  cmac_axis_pkt_gen dut (
    .clk             (clk),
    .sys_reset_n     (sys_reset_n),
    .start           (start),
    .send_continuous (send_continuous),
    .stat_rx_aligned (stat_rx_aligned),
    .num_pkts        (num_pkts),
    .pkt_len         (pkt_len),
    .tx_axis_tready  (tx_axis_tready),
    .tx_axis_tvalid  (tx_axis_tvalid),
    .tx_axis_tdata   (tx_axis_tdata),
    .tx_axis_tkeep   (tx_axis_tkeep),
    .tx_axis_tlast   (tx_axis_tlast),
    .tx_busy         (tx_busy),
    .tx_done         (tx_done),
    .pkts_sent       (pkts_sent)
  );

  typedef struct {
    int          len;
    int          npk;
    int          low_pct;
    bit          mid_start;
    int          exp_len;
    int          exp_beats;
    logic [63:0] exp_lkeep;
  } vec_t;

  vec_t vecs[6];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [576:0] exp_beat(input int f, input int b, input int lenc,
                                            input int nb, input logic [63:0] lkeep);
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    l = (b == nb - 1);
    k = l ? lkeep : '1;
    d = '0;
    for (int i = 0; i < 64; i++)
      if (64 * b + i < lenc) d[8*i +: 8] = 8'((f + 64 * b + i) & 255);
    return {l, k, d};
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int frames, beat, first_cyc, low_run, cyc;
    bit gap_pending, stall;
    logic [576:0] held;
    pkt_len = 14'(v.len);
    num_pkts = 16'(v.npk);
    tx_axis_tready = 1'b1;
    pulse_start();
    frames = 0; beat = 0; first_cyc = -1; low_run = 0;
    gap_pending = 1'b0; stall = 1'b0; held = '0;
    for (cyc = 0; cyc < 6000 && !tx_done; cyc++) begin
      tx_axis_tready = (v.low_pct == 0) ? 1'b1 : ($urandom_range(99) >= 32'(v.low_pct));
      start = v.mid_start && (cyc == 5);
      if (stall)
        chk({nm, "_stall_hold"}, 640'({tx_axis_tvalid, tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata}),
            640'({1'b1, held}));
      if (tx_axis_tvalid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          chk({nm, "_first_latency"}, 640'(cyc), 640'(1));
        end
        if (gap_pending && v.low_pct == 0)
          chk({nm, "_idle_between"}, 640'(low_run), 640'(3));
        gap_pending = 1'b0;
        chk($sformatf("%s_f%0d_b%0d", nm, frames, beat),
            640'({tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata}),
            640'(exp_beat(frames, beat, v.exp_len, v.exp_beats, v.exp_lkeep)));
        stall = !tx_axis_tready;
        held = {tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata};
        if (tx_axis_tready) begin
          if (tx_axis_tlast) begin
            chk({nm, "_beats"}, 640'(beat + 1), 640'(v.exp_beats));
            $display("%s frame %0d: %0d beats", nm, frames, beat + 1);
            frames++;
            beat = 0;
            gap_pending = 1'b1;
            low_run = 0;
          end else begin
            beat++;
          end
        end
      end else begin
        stall = 1'b0;
        if (gap_pending) low_run++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, "_done"}, 640'(tx_done), 640'(1));
    chk({nm, "_frames"}, 640'(frames), 640'(v.npk));
    chk({nm, "_pkts_sent"}, 640'(pkts_sent), 640'(v.npk));
  endtask

  initial begin
    int vseen, frames, beat, xf;
    vecs[0] = '{64,    1,  0, 1'b0, 64,   1,   64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1] = '{130,   3,  0, 1'b1, 130,  3,   64'h0000_0000_0000_0003};
    vecs[2] = '{10,    2,  0, 1'b0, 64,   1,   64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{12000, 1,  0, 1'b0, 9600, 150, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{1500,  20, 30, 1'b0, 1500, 24,  64'h0000_0000_0FFF_FFFF};
    vecs[5] = '{100,   2,  0, 1'b0, 100,  2,   64'h0000_000F_FFFF_FFFF};

    // Reset values
    sys_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 640'({tx_axis_tvalid, tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata,
                               tx_busy, tx_done, pkts_sent}), 640'(0));

    // start on the first edge after release must be ignored
    sys_reset_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sync_ignore", 640'({tx_busy, tx_done}), 640'(0));

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Zero count: DONE two cycles after start, no tvalid
    pkt_len = 14'd64;
    num_pkts = 16'd0;
    pulse_start();
    chk("zero_busy", 640'({tx_busy, tx_done, tx_axis_tvalid}), 640'(3'b100));
    @(negedge clk);
    chk("zero_done", 640'({tx_busy, tx_done, tx_axis_tvalid}), 640'(3'b010));
    chk("zero_pkts", 640'(pkts_sent), 640'(0));
    $display("zero-count run: done");

    // Alignment gating
    stat_rx_aligned = 1'b0;
    num_pkts = 16'd1;
    pulse_start();
    vseen = 0;
    repeat (100) begin
      @(negedge clk);
      vseen += int'(tx_axis_tvalid);
    end
    chk("align_hold", 640'(vseen), 640'(0));
    stat_rx_aligned = 1'b1;
    @(negedge clk);
    chk("align_first", 640'({tx_axis_tvalid, tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata}),
        640'({1'b1, exp_beat(0, 0, 64, 1, '1)}));
    for (int i = 0; i < 20 && !tx_done; i++) @(negedge clk);
    chk("align_pkts", 640'({tx_done, pkts_sent}), 640'({1'b1, 32'd1}));
    $display("alignment-gated run: done");

    // Continuous mode: drop send_continuous during frame 3
    send_continuous = 1'b1;
    num_pkts = 16'd1;
    pkt_len = 14'd1500;
    pulse_start();
    frames = 0;
    beat = 0;
    for (int i = 0; i < 2000 && !tx_done; i++) begin
      if (tx_axis_tvalid && tx_axis_tready) begin
        if (tx_axis_tlast) begin
          frames++;
          beat = 0;
          $display("continuous frame %0d sent", frames);
        end else begin
          beat++;
        end
      end
      if (frames == 2 && beat == 3) send_continuous = 1'b0;
      @(negedge clk);
    end
    chk("cont_frames", 640'(frames), 640'(3));
    chk("cont_done", 640'({tx_done, tx_busy, pkts_sent}), 640'({2'b10, 32'd3}));

    // Asynchronous reset while beat 5 of a 1500-byte frame is presented
    num_pkts = 16'd1;
    pulse_start();
    xf = 0;
    for (int i = 0; i < 30 && xf < 5; i++) begin
      if (tx_axis_tvalid && tx_axis_tready) xf++;
      @(negedge clk);
    end
    chk("rst_pre_valid", 640'({tx_axis_tvalid, tx_busy}), 640'(2'b11));
    #2;
    sys_reset_n = 1'b0;
    #1;
    chk("rst_async", 640'({tx_axis_tvalid, tx_axis_tdata, tx_busy, pkts_sent}), 640'(0));
    @(negedge clk);
    sys_reset_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("mid-frame reset applied");
    run_vec(vecs[1], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
